keypad_scanner: RTL and testbench

- Scans a 4x4 vending-machine keypad matrix and debounces presses.
- Reports each accepted press once, as a row index (`linha`) and column index (`coluna`), over a valid/ready handshake.
- Sits directly upstream of the product selector: its `linha`/`coluna` outputs feed the selector's `linha`/`coluna` inputs.
- One physical press yields exactly one report; the key must be released before another report is produced.

---
 rtl/keypad_pkg.sv | 35 +++
 rtl/keypad_scanner_sync2.sv | 38 +++
 rtl/keypad_scanner.sv | 208 ++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared types, constants and helper functions for the 4x4 keypad scanner.
//   kp_state_e     : scanner FSM states (SCAN, DEBOUNCE, REPORT, RELEASE)
//   KP_ROWS/KP_COLS: matrix dimensions
//   onehot_to_idx  : 4-bit one-hot row pattern -> 2-bit index
//   is_onehot      : 1 when exactly one bit of a 4-bit pattern is set
// -----------------------------------------------------------------------------
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    REPORT   = 2'd2,
    RELEASE  = 2'd3
  } kp_state_e;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;

  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // v & (v-1) clears the lowest set bit; zero result with v != 0 means one bit.
  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// -----------------------------------------------------------------------------
// keypad_sync2
// Two-flop synchronizer for the raw keypad row lines.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (flops clear to 0)
//   d        : raw asynchronous row inputs
//   q        : synchronized rows (two clk cycles of latency)
// -----------------------------------------------------------------------------
module keypad_sync2
  import keypad_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [KP_ROWS-1:0] d,
  output logic [KP_ROWS-1:0] q
);

  logic [KP_ROWS-1:0] sync1_q, sync1_d;
  logic [KP_ROWS-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = d;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign q = sync2_q;

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 vending-machine keypad, debounces a single pressed key and
// reports it once as (linha, coluna) over a valid/ready handshake. The key
// must be released before another report can be produced.
//
// Parameters:
//   SCAN_DIV        : cycles each column is strobed (>= 4)
//   DEBOUNCE_CYCLES : stable cycles required for press and for release (>= 1)
// Build option:
//   KEYPAD_DEBOUNCE_EN : when defined, presses are debounced (DEBOUNCE state)
//                        and release needs DEBOUNCE_CYCLES zero cycles; when
//                        undefined a one-hot sample reports immediately and
//                        release exits on the first all-zero sample.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   row_in    : raw row lines (async), bit r = key in row r of driven column
//   col_drive : one-hot active-high column strobe
//   linha     : row index of the reported key
//   coluna    : column index of the reported key
//   valid     : report available
//   ready     : downstream accept
//
// Handshake: valid rises together with stable linha/coluna and stays high
// until a cycle where valid && ready; valid is low on the next cycle. ready
// has no effect while valid is low. All outputs come straight from flops.
// -----------------------------------------------------------------------------
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KP_ROWS-1:0] row_in,
  output logic [KP_COLS-1:0] col_drive,
  output logic [1:0]         linha,
  output logic [1:0]         coluna,
  output logic               valid,
  input  logic               ready
);

  localparam int              DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  // Stop elaboration on parameter values the scan timing cannot support.
  if (SCAN_DIV < 4 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
    $error("keypad_scanner: SCAN_DIV must be >= 4 and DEBOUNCE_CYCLES >= 1");
  end

  logic [KP_ROWS-1:0] row_s;

  keypad_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (row_in),
    .q   (row_s)
  );

  kp_state_e          state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [1:0]         col_idx_q, col_idx_d;
  logic [KP_COLS-1:0] col_drive_q, col_drive_d;
  logic [1:0]         linha_q, linha_d;
  logic [1:0]         coluna_q, coluna_d;
  logic               valid_q, valid_d;

`ifdef KEYPAD_DEBOUNCE_EN
  localparam int               DEB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
  // Row pattern captured at the sample cycle; debounce compares against it.
  logic [KP_ROWS-1:0] row_cap_q, row_cap_d;
`endif

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    col_idx_d = col_idx_q;
    linha_d   = linha_q;
    coluna_d  = coluna_q;
    valid_d   = valid_q;
`ifdef KEYPAD_DEBOUNCE_EN
    deb_cnt_d = deb_cnt_q;
    row_cap_d = row_cap_q;
`endif

    case (state_q)
      SCAN: begin
        div_d = div_q + DIV_W'(1);
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (is_onehot(row_s)) begin
            // Column is kept: the key stays strobed while it is qualified.
`ifdef KEYPAD_DEBOUNCE_EN
            row_cap_d = row_s;
            deb_cnt_d = '0;
            state_d   = DEBOUNCE;
`else
            linha_d   = onehot_to_idx(row_s);
            coluna_d  = col_idx_q;
            valid_d   = 1'b1;
            state_d   = REPORT;
`endif
          end else begin
            // No key, or several rows at once (ghosting): move on.
            col_idx_d = col_idx_q + 2'd1;
          end
        end
      end

`ifdef KEYPAD_DEBOUNCE_EN
      DEBOUNCE: begin
        if (row_s == row_cap_q) begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
          // deb_cnt_d reaches DEBOUNCE_CYCLES on this cycle.
          if (deb_cnt_q == DEB_LAST) begin
            linha_d  = onehot_to_idx(row_cap_q);
            coluna_d = col_idx_q;
            valid_d  = 1'b1;
            state_d  = REPORT;
          end
        end else begin
          col_idx_d = col_idx_q + 2'd1;
          div_d     = '0;
          state_d   = SCAN;
        end
      end
`endif

      REPORT: begin
        // row_s is ignored here: a key released now is still reported.
        if (valid_q && ready) begin
          valid_d = 1'b0;
`ifdef KEYPAD_DEBOUNCE_EN
          deb_cnt_d = '0;
`endif
          state_d = RELEASE;
        end
      end

      RELEASE: begin
`ifdef KEYPAD_DEBOUNCE_EN
        if (row_s == '0) begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
          if (deb_cnt_q == DEB_LAST) begin
            col_idx_d = col_idx_q + 2'd1;
            div_d     = '0;
            state_d   = SCAN;
          end
        end else begin
          deb_cnt_d = '0;
        end
`else
        if (row_s == '0) begin
          col_idx_d = col_idx_q + 2'd1;
          div_d     = '0;
          state_d   = SCAN;
        end
`endif
      end

      default: begin
        state_d = SCAN;
        div_d   = '0;
      end
    endcase

    // Strobe follows the next column index so col_drive is a plain flop.
    col_drive_d = KP_COLS'(1) << col_idx_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SCAN;
      div_q       <= '0;
      col_idx_q   <= 2'd0;
      col_drive_q <= KP_COLS'(1);
      linha_q     <= 2'd0;
      coluna_q    <= 2'd0;
      valid_q     <= 1'b0;
`ifdef KEYPAD_DEBOUNCE_EN
      deb_cnt_q   <= '0;
      row_cap_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      col_idx_q   <= col_idx_d;
      col_drive_q <= col_drive_d;
      linha_q     <= linha_d;
      coluna_q    <= coluna_d;
      valid_q     <= valid_d;
`ifdef KEYPAD_DEBOUNCE_EN
      deb_cnt_q   <= deb_cnt_d;
      row_cap_q   <= row_cap_d;
`endif
    end
  end

  assign col_drive = col_drive_q;
  assign linha     = linha_q;
  assign coluna    = coluna_q;
  assign valid     = valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
// Directed bench for keypad_scanner (SCAN_DIV = 4, DEBOUNCE_CYCLES = 8).
// A behavioural keypad drives row_in from col_drive and the pressed key.
// Expected latencies follow the KEYPAD_DEBOUNCE_EN build option.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;

`ifdef KEYPAD_DEBOUNCE_EN
  // Strobe at cycle 0, sample at cycle 3, valid at 3 + DEB + 1.
  localparam int REP_LAT = (SCAN_DIV - 1) + DEB + 1;
  // Key lifted in cycle r: row_s zero from r+2, DEB zero cycles, new column at r+2+DEB.
  localparam int REL_LAT = 2 + DEB;
`else
  localparam int REP_LAT = (SCAN_DIV - 1) + 1;
  localparam int REL_LAT = 3;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       ready;
  logic [3:0] row_in;
  logic [3:0] col_drive;
  logic [1:0] linha, coluna;
  logic       valid;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .col_drive (col_drive),
    .linha     (linha),
    .coluna    (coluna),
    .valid     (valid),
    .ready     (ready)
  );

  // ---------------- keypad model ----------------
  logic       key_down;
  logic [1:0] key_row, key_col;
  logic       ghost_en;
  logic [1:0] ghost_col;
  logic [3:0] ghost_pat;

  always_comb begin
    row_in = 4'b0000;
    if (key_down && col_drive[key_col]) row_in[key_row] = 1'b1;
    if (ghost_en && col_drive[ghost_col]) row_in = row_in | ghost_pat;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the bench on the negedge where rst drops (div = 0, column 0).
  task automatic do_reset();
    key_down = 1'b0;
    ghost_en = 1'b0;
    ready    = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_strobe(input string name, input logic [1:0] col);
    int guard;
    logic [3:0] tgt;
    tgt = 4'b0001 << col;
    guard = 0;
    while (col_drive == tgt && guard < 64) begin tick(); guard++; end
    guard = 0;
    while (col_drive != tgt && guard < 64) begin tick(); guard++; end
    check({name, " strobe"}, col_drive, tgt);
  endtask

  task automatic wait_report(input string name, input logic [1:0] col, input logic [1:0] row);
    int lat;
    wait_strobe(name, col);
    lat = 0;
    while (!valid && lat < 100) begin tick(); lat++; end
    check({name, " latency"}, lat, REP_LAT);
    check({name, " linha"}, linha, row);
    check({name, " coluna"}, coluna, col);
  endtask

  task automatic accept(input string name);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check({name, " valid drop"}, valid, 1'b0);
  endtask

  task automatic quiet(input string name, input int cycles);
    int hits;
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (valid) hits++;
    end
    check({name, " valid cycles"}, hits, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       ready;
    logic [3:0] exp_col;
    logic       exp_valid;
  } vec_t;

  vec_t vecs[16];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // entry i is sampled after i+1 clock edges following reset release
    vecs[0]  = '{1'b0, 4'b0001, 1'b0};
    vecs[1]  = '{1'b1, 4'b0001, 1'b0};
    vecs[2]  = '{1'b0, 4'b0001, 1'b0};
    vecs[3]  = '{1'b1, 4'b0010, 1'b0};
    vecs[4]  = '{1'b1, 4'b0010, 1'b0};
    vecs[5]  = '{1'b0, 4'b0010, 1'b0};
    vecs[6]  = '{1'b0, 4'b0010, 1'b0};
    vecs[7]  = '{1'b1, 4'b0100, 1'b0};
    vecs[8]  = '{1'b0, 4'b0100, 1'b0};
    vecs[9]  = '{1'b1, 4'b0100, 1'b0};
    vecs[10] = '{1'b0, 4'b0100, 1'b0};
    vecs[11] = '{1'b0, 4'b1000, 1'b0};
    vecs[12] = '{1'b1, 4'b1000, 1'b0};
    vecs[13] = '{1'b1, 4'b1000, 1'b0};
    vecs[14] = '{1'b0, 4'b1000, 1'b0};
    vecs[15] = '{1'b0, 4'b0001, 1'b0};

    rst       = 1'b1;
    ready     = 1'b0;
    key_down  = 1'b0;
    key_row   = 2'd0;
    key_col   = 2'd0;
    ghost_en  = 1'b0;
    ghost_col = 2'd2;
    ghost_pat = 4'b0101;

    // 1. reset values and free-running scan
    @(negedge clk);
    @(negedge clk);
    check("rst col_drive", col_drive, 4'b0001);
    check("rst valid", valid, 1'b0);
    check("rst linha", linha, 2'd0);
    check("rst coluna", coluna, 2'd0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ready = vecs[i].ready;
      tick();
      check($sformatf("scan[%0d] col_drive", i), col_drive, vecs[i].exp_col);
      check($sformatf("scan[%0d] valid", i), valid, vecs[i].exp_valid);
    end
    ready = 1'b0;
    check("scan linha", linha, 2'd0);
    check("scan coluna", coluna, 2'd0);

    // 2. clean press row 1 / column 1, hold with ready low, accept, release
    do_reset();
    key_row = 2'd1; key_col = 2'd1; key_down = 1'b1;
    wait_report("press", 2'd1, 2'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("hold[%0d] valid", i), valid, 1'b1);
      check($sformatf("hold[%0d] linha", i), linha, 2'd1);
      check($sformatf("hold[%0d] col_drive", i), col_drive, 4'b0010);
    end
    accept("press");
    key_down = 1'b0;
    for (int i = 0; i < REL_LAT - 1; i++) tick();
    check("release hold col_drive", col_drive, 4'b0010);
    tick();
    check("release exit col_drive", col_drive, 4'b0100);
    check("release keeps linha", linha, 2'd1);
    check("release keeps coluna", coluna, 2'd1);

`ifdef KEYPAD_DEBOUNCE_EN
    // 3. bounce: key drops so row_s mismatches at debounce cycle 5
    do_reset();
    key_row = 2'd2; key_col = 2'd2; key_down = 1'b1;
    wait_strobe("bounce", 2'd2);
    for (int i = 0; i < 6; i++) tick();
    key_down = 1'b0;
    tick();
    tick();
    check("bounce mismatch col_drive", col_drive, 4'b0100);
    check("bounce valid", valid, 1'b0);
    tick();
    check("bounce resume col_drive", col_drive, 4'b1000);
    quiet("bounce", 20);
`endif

    // 4. ghosting: two rows on column 2
    do_reset();
    ghost_en = 1'b1;
    quiet("ghost", 40);
    check("ghost col_drive", col_drive, 4'b0100);
    ghost_en = 1'b0;

    // 5. release rules
    do_reset();
    key_row = 2'd1; key_col = 2'd1; key_down = 1'b1;
    wait_report("rel first", 2'd1, 2'd1);
    accept("rel first");
    quiet("rel held", 100);
    check("rel held col_drive", col_drive, 4'b0010);
`ifdef KEYPAD_DEBOUNCE_EN
    key_down = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    key_down = 1'b1;
    quiet("rel repress", 10);
    check("rel repress col_drive", col_drive, 4'b0010);
`endif
    key_down = 1'b0;
    quiet("rel released", 40);
    key_row = 2'd3; key_col = 2'd0; key_down = 1'b1;
    wait_report("rel fresh", 2'd0, 2'd3);

    // 6. asynchronous reset while reporting
    #2;
    rst = 1'b1;
    #1;
    check("async rst valid", valid, 1'b0);
    check("async rst col_drive", col_drive, 4'b0001);
    check("async rst linha", linha, 2'd0);
    check("async rst coluna", coluna, 2'd0);
    key_down = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
